// File: rtl/munoc_link_isolation_ctrl.sv
// Link isolation controller: isolates a MUNOC link only at packet boundaries, then acks once drained.
// Latency: link_block rises 1 cycle after iso_req is sampled on an idle link; iso_ack follows 1 cycle later.
// Backpressure: link_block gates new request packets (credit limit / isolation); never mid-packet, low in FAIL.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   iso_req             level request to isolate the link
//   iso_ack             high while the link is isolated
//   iso_timeout         one-cycle pulse when a drain gives up
//   req_valid/ready/last   request channel, observed on the gated side
//   rsp_valid/ready/last   response channel, observed on the gated side
//   link_block          drives the gating stage's block input (register-only path)
//   outstanding         transactions started but not yet answered
//   err_underflow       sticky: a response arrived with nothing outstanding
//   err_clear           clears err_underflow (a same-cycle underflow wins)
module munoc_link_isolation_ctrl #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TO_W            = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iso_req,
  output logic             iso_ack,
  output logic             iso_timeout,
  input  logic             req_valid,
  input  logic             req_ready,
  input  logic             req_last,
  input  logic             rsp_valid,
  input  logic             rsp_ready,
  input  logic             rsp_last,
  output logic             link_block,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_underflow,
  input  logic             err_clear
);

  typedef enum logic [1:0] {
    ST_OPEN     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2,
    ST_FAIL     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_FULL = '1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t           state;
  state_t           state_nxt;
  logic             req_inpkt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_fire;
  logic             underflow;

  logic req_hs;
  logic rsp_hs;
  logic txn_start;
  logic txn_end;

  assign req_hs    = req_valid & req_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign txn_start = req_hs & req_last;
  assign txn_end   = rsp_hs & rsp_last;

  // ---------------------------------------------------------------------------
  // FSM next-state. DRAIN priority: abort, then drained, then timeout.
  // "Drained" uses the registered count and packet flag, so a last response
  // landing this cycle is seen as drained one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    timeout_fire = 1'b0;
    case (state)
      ST_OPEN: begin
        if (iso_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!iso_req) begin
          state_nxt = ST_OPEN;
        end else if (!req_inpkt && (cnt_q == '0)) begin
          state_nxt = ST_ISOLATED;
        end else if (TO_EN && (to_cnt == TO_LIMIT)) begin
          state_nxt    = ST_FAIL;
          timeout_fire = 1'b1;
        end
      end
      ST_ISOLATED: begin
        if (!iso_req) state_nxt = ST_OPEN;
      end
      ST_FAIL: begin
        // Sticks until iso_req drops, so a retry needs a fresh rising request.
        if (!iso_req) state_nxt = ST_OPEN;
      end
      default: state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter. A start and an end in the same cycle cancel out.
  // An end with nothing outstanding is flagged instead of wrapping.
  // The increment saturates at full scale: in FAIL the gate is open, so a
  // misbehaving requester could otherwise wrap the count back to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_nxt   = cnt_q;
    underflow = 1'b0;
    if (txn_start && !txn_end) begin
      if (cnt_q != CNT_FULL) cnt_nxt = cnt_q + CNT_W'(1);
    end else if (txn_end && !txn_start) begin
      if (cnt_q == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_nxt = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      req_inpkt     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (req_hs) req_inpkt <= ~req_last;
      if (underflow) begin
        err_underflow <= 1'b1;
      end else if (err_clear) begin
        err_underflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain timer: counts cycles spent in DRAIN, zero elsewhere. It only needs
  // to reach TO_LIMIT; DRAIN is always left on that cycle, so no saturation.
  // With the timeout disabled it simply wraps unused.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      iso_timeout <= 1'b0;
    end else begin
      if (state == ST_DRAIN) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
      // Registered so the pulse lines up with the first FAIL cycle.
      iso_timeout <= timeout_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, so the gate sees no combinational
  // path from the link handshakes. req_inpkt masks every blocking term so a
  // packet in progress always completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    link_block = ((state == ST_DRAIN) && !req_inpkt)
              || (state == ST_ISOLATED)
              || ((state == ST_OPEN) && !req_inpkt && (cnt_q == CNT_MAX));
  end

  assign iso_ack     = (state == ST_ISOLATED);
  assign outstanding = cnt_q;

endmodule
